// File: rtl/pwm_multi.sv
// pwm_multi: multi-channel PWM, shared prescaler and period counter,
// edge/center-aligned modes, duties double-buffered to period boundaries.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-low reset
//   en           global enable
//   center       mode request, 1 = center-aligned, taken at boundaries
//   duty         packed duties, channel i at [i*NBITS +: NBITS]
//   load         strobe: capture duty into the shadow register
//   inv          per-channel output inversion
//   out          registered PWM outputs
//   pending      shadow holds a duty set not yet made active
//   period_start one-cycle pulse at each period boundary

`ifndef PWM_RES
`define PWM_RES 8
`endif
`ifndef PWM_FREQ
`define PWM_FREQ 1000
`endif

module pwm_multi #(
  parameter int CHANNELS = 4,
  parameter int NBITS    = `PWM_RES,
  parameter int FREQ     = `PWM_FREQ,
  parameter int CLK_FREQ = 48000000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      center,
  input  logic [CHANNELS*NBITS-1:0] duty,
  input  logic                      load,
  input  logic [CHANNELS-1:0]       inv,
  output logic [CHANNELS-1:0]       out,
  output logic                      pending,
  output logic                      period_start
);

  localparam int DIV = CLK_FREQ / (FREQ * (2 ** NBITS)) - 1;
  localparam int DIV_C = (DIV < 0) ? 0 : DIV;
  localparam int PW = (DIV_C < 2) ? 1 : $clog2(DIV_C + 1);
  localparam logic [PW-1:0] DIV_V = PW'(DIV_C);
  localparam logic [NBITS-1:0] MAX = '1;
  localparam logic [NBITS-1:0] ONE = NBITS'(1);
  localparam bit SHORT = (NBITS == 1);

  if (DIV < 0) begin : g_div_chk
    $fatal(1, "pwm_multi: CLK_FREQ too low for FREQ and NBITS");
  end

  if (CHANNELS < 1 || CHANNELS > 16) begin : g_ch_chk
    $fatal(1, "pwm_multi: CHANNELS must be 1..16");
  end

  logic [PW-1:0]             psc;
  logic [PW-1:0]             psc_n;
  logic [NBITS-1:0]          cnt;
  logic [NBITS-1:0]          cnt_n;
  logic                      dir_dn;
  logic                      dir_n;
  logic                      ctr_mode;
  logic                      en_q;
  logic [CHANNELS*NBITS-1:0] shadow;
  logic [CHANNELS*NBITS-1:0] active;
  logic [CHANNELS-1:0]       out_n;

  logic tick;
  logic edge_end;
  logic ctr_end;
  logic bnd;
  logic adv;

  // A period ends on the tick that would leave the last count.
  // The first enabled cycle is also a boundary so that a freshly
  // enabled block starts a clean period with the shadow duties.
  always_comb begin
    tick     = (psc == DIV_V);
    edge_end = tick & ~ctr_mode & (cnt == MAX);
    ctr_end  = tick & ctr_mode &
               ((dir_dn & (cnt == ONE)) |
                (SHORT & ~dir_dn & (cnt == MAX)));
    bnd      = en & (~en_q | edge_end | ctr_end);
    adv      = en & ~bnd & tick;
  end

  always_comb begin
    psc_n = psc;
    cnt_n = cnt;
    dir_n = dir_dn;
    unique case (1'b1)
      !en, bnd: begin
        psc_n = '0;
        cnt_n = '0;
        dir_n = 1'b0;
      end
      adv: begin
        psc_n = '0;
        unique case (1'b1)
          !ctr_mode: cnt_n = cnt + 1'b1;
          ctr_mode && !dir_dn && cnt == MAX: begin
            cnt_n = cnt - 1'b1;
            dir_n = 1'b1;
          end
          ctr_mode && !dir_dn && cnt != MAX:
            cnt_n = cnt + 1'b1;
          default: cnt_n = cnt - 1'b1;
        endcase
      end
      default: psc_n = psc + 1'b1;
    endcase
  end

  always_comb begin
    out_n = inv;
    if (en) begin
      for (int i = 0; i < CHANNELS; i++) begin
        out_n[i] = (cnt < active[i*NBITS +: NBITS]) ^ inv[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      psc          <= '0;
      cnt          <= '0;
      dir_dn       <= 1'b0;
      ctr_mode     <= 1'b0;
      en_q         <= 1'b0;
      shadow       <= '0;
      active       <= '0;
      pending      <= 1'b0;
      period_start <= 1'b0;
      out          <= '0;
    end else begin
      psc          <= psc_n;
      cnt          <= cnt_n;
      dir_dn       <= dir_n;
      en_q         <= en;
      out          <= out_n;
      period_start <= bnd;
      if (bnd) begin
        active   <= shadow;
        ctr_mode <= center;
      end
      // A load on a boundary still wins: the old shadow moves to
      // active and the new one stays pending.
      if (load) begin
        shadow  <= duty;
        pending <= 1'b1;
      end else if (bnd) begin
        pending <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pwm_multi.sv
// tb_pwm_multi: two pwm_multi instances (prescaler 0 and 2) driven
// together and compared against a period-position reference model.
module tb_pwm_multi;

  localparam int CH = 2;
  localparam int NB = 4;
  localparam int MX = 15;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en = 1'b0;
  logic center = 1'b0;
  logic load = 1'b0;
  logic [CH*NB-1:0] duty = '0;
  logic [CH-1:0] inv = '0;

  logic [CH-1:0] out_a, out_b;
  logic pend_a, pend_b, ps_a, ps_b;
  logic [CH+1:0] obs_a, obs_b;

  int n_run = 0;
  int n_fail = 0;

  assign obs_a = {pend_a, ps_a, out_a};
  assign obs_b = {pend_b, ps_b, out_b};

  always #5 clk = ~clk;

  pwm_multi #(
    .CHANNELS(CH), .NBITS(NB), .FREQ(1), .CLK_FREQ(16)
  ) dut_a (
    .clk(clk), .rst(rst), .en(en), .center(center),
    .duty(duty), .load(load), .inv(inv), .out(out_a),
    .pending(pend_a), .period_start(ps_a)
  );

  pwm_multi #(
    .CHANNELS(CH), .NBITS(NB), .FREQ(1), .CLK_FREQ(48)
  ) dut_b (
    .clk(clk), .rst(rst), .en(en), .center(center),
    .duty(duty), .load(load), .inv(inv), .out(out_b),
    .pending(pend_b), .period_start(ps_b)
  );

  // Model state: position inside the current period and clocks since
  // the last tick, rather than a counter with a direction flag.
  typedef struct {
    int pos;
    int sub;
    int div;
    logic [CH-1:0][NB-1:0] act;
    logic [CH-1:0][NB-1:0] shd;
    logic mode;
    logic pend;
    logic ps;
    logic en_prev;
    logic [CH-1:0] out;
  } mdl_t;

  mdl_t m [2];

  function automatic mdl_t mdl_reset(int div);
    mdl_t r;
    r.pos = 0;
    r.sub = 0;
    r.div = div;
    r.act = '0;
    r.shd = '0;
    r.mode = 1'b0;
    r.pend = 1'b0;
    r.ps = 1'b0;
    r.en_prev = 1'b0;
    r.out = '0;
    return r;
  endfunction

  function automatic mdl_t mdl_step(mdl_t s);
    mdl_t n;
    int per;
    int lvl;
    logic tk;
    logic bnd;
    n = s;
    bnd = 1'b0;
    if (!en) begin
      n.pos = 0;
      n.sub = 0;
      n.ps = 1'b0;
      n.out = inv;
    end else begin
      per = s.mode ? 2 * MX : MX + 1;
      lvl = (s.mode && s.pos > MX) ? 2 * MX - s.pos : s.pos;
      for (int i = 0; i < CH; i++)
        n.out[i] = (lvl < int'(s.act[i])) ^ inv[i];
      tk = (s.sub == s.div);
      bnd = !s.en_prev || (tk && s.pos == per - 1);
      if (bnd) begin
        n.pos = 0;
        n.sub = 0;
        n.act = s.shd;
        n.mode = center;
      end else if (tk) begin
        n.pos = s.pos + 1;
        n.sub = 0;
      end else begin
        n.sub = s.sub + 1;
      end
      n.ps = bnd;
    end
    n.en_prev = en;
    if (load) begin
      n.shd = duty;
      n.pend = 1'b1;
    end else if (bnd) begin
      n.pend = 1'b0;
    end
    return n;
  endfunction

  function automatic logic [CH+1:0] exp_v(int k);
    return {m[k].pend, m[k].ps, m[k].out};
  endfunction

  task automatic cyc(int n = 1);
    repeat (n) begin
      @(posedge clk);
      m[0] = mdl_step(m[0]);
      m[1] = mdl_step(m[1]);
      #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #12;
    n_run++;
    if ({obs_a, obs_b} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got %b want 0", {obs_a, obs_b});
    end
    m[0] = mdl_reset(0);
    m[1] = mdl_reset(2);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      n_run += 2;
      if (obs_a !== exp_v(0)) begin
        n_fail++;
        $display("FAIL reset_idle_a: got %b want %b", obs_a, exp_v(0));
      end
      if (obs_b !== exp_v(1)) begin
        n_fail++;
        $display("FAIL reset_idle_b: got %b want %b", obs_b, exp_v(1));
      end
    end
  endtask

  task automatic test_edge();
    int h0, h1, np, hb0, npb;
    h0 = 0; h1 = 0; np = 0; hb0 = 0; npb = 0;
    center = 1'b0;
    duty = {4'd12, 4'd4};
    load = 1'b1;
    cyc();
    load = 1'b0;
    n_run++;
    if (pend_a !== 1'b1) begin
      n_fail++;
      $display("FAIL edge_pending: got %b want 1", pend_a);
    end
    en = 1'b1;
    for (int i = 0; i < 100; i++) begin
      cyc();
      n_run += 2;
      if (obs_a !== exp_v(0)) begin
        n_fail++;
        $display("FAIL edge_a cyc %0d: got %b want %b", i, obs_a, exp_v(0));
      end
      if (obs_b !== exp_v(1)) begin
        n_fail++;
        $display("FAIL edge_b cyc %0d: got %b want %b", i, obs_b, exp_v(1));
      end
      if (i >= 4 && i < 36) begin
        h0 += int'(out_a[0]);
        h1 += int'(out_a[1]);
        np += int'(ps_a);
      end
      if (i >= 4) begin
        hb0 += int'(out_b[0]);
        npb += int'(ps_b);
      end
    end
    n_run += 5;
    if (h0 != 8) begin
      n_fail++;
      $display("FAIL edge_high_ch0: got %0d want 8", h0);
    end
    if (h1 != 24) begin
      n_fail++;
      $display("FAIL edge_high_ch1: got %0d want 24", h1);
    end
    if (np != 2) begin
      n_fail++;
      $display("FAIL edge_period_starts: got %0d want 2", np);
    end
    if (hb0 != 24) begin
      n_fail++;
      $display("FAIL edge_high_div2: got %0d want 24", hb0);
    end
    if (npb != 2) begin
      n_fail++;
      $display("FAIL edge_period_starts_div2: got %0d want 2", npb);
    end
  endtask

  task automatic test_center();
    int ps_idx[$];
    logic samp [30];
    int hi, start, bad, sp;
    hi = 0; start = -1; bad = 0;
    center = 1'b1;
    duty = {4'd10, 4'd5};
    load = 1'b1;
    cyc();
    load = 1'b0;
    for (int i = 0; i < 200; i++) begin
      cyc();
      n_run += 2;
      if (obs_a !== exp_v(0)) begin
        n_fail++;
        $display("FAIL center_a cyc %0d: got %b want %b", i, obs_a, exp_v(0));
      end
      if (obs_b !== exp_v(1)) begin
        n_fail++;
        $display("FAIL center_b cyc %0d: got %b want %b", i, obs_b, exp_v(1));
      end
      if (ps_a) ps_idx.push_back(i);
      if (i >= 140) hi += int'(out_a[0]);
      if (start < 0 && ps_a && i >= 60) start = i;
      else if (start >= 0 && i > start && i <= start + 30)
        samp[i-start-1] = out_a[0];
    end
    n_run++;
    if (hi != 18) begin
      n_fail++;
      $display("FAIL center_high: got %0d want 18", hi);
    end
    n_run++;
    sp = (ps_idx.size() >= 2) ?
         ps_idx[ps_idx.size()-1] - ps_idx[ps_idx.size()-2] : -1;
    if (sp != 30) begin
      n_fail++;
      $display("FAIL center_period: got %0d want 30", sp);
    end
    n_run++;
    if (start < 0) begin
      n_fail++;
      $display("FAIL center_sym: got no boundary want one");
    end else begin
      for (int k = 1; k < 30; k++)
        if (samp[k] !== samp[30-k]) bad++;
      if (bad != 0 || samp[0] !== 1'b1) begin
        n_fail++;
        $display("FAIL center_sym: got %0d asymmetric want 0", bad);
      end
    end
  endtask

  task automatic test_last_wins();
    bit found;
    int h;
    h = 0;
    center = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      cyc();
      if (ps_a) found = 1'b1;
    end
    m[0] = m[0];
    cyc(3);
    duty[3:0] = 4'd8;
    load = 1'b1;
    cyc();
    load = 1'b0;
    n_run++;
    if (pend_a !== 1'b1) begin
      n_fail++;
      $display("FAIL last_pending_set: got %b want 1", pend_a);
    end
    cyc(2);
    duty[3:0] = 4'd2;
    load = 1'b1;
    cyc();
    load = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      cyc();
      n_run += 2;
      if (obs_a !== exp_v(0)) begin
        n_fail++;
        $display("FAIL last_a cyc %0d: got %b want %b", i, obs_a, exp_v(0));
      end
      if (ps_a) begin
        found = 1'b1;
      end else if (pend_a !== 1'b1) begin
        n_fail++;
        $display("FAIL last_pending_hold: got %b want 1", pend_a);
      end
    end
    n_run++;
    if (!found || pend_a !== 1'b0) begin
      n_fail++;
      $display("FAIL last_boundary: got ps %b pend %b want 1 0", ps_a, pend_a);
    end
    for (int i = 0; i < 16; i++) begin
      cyc();
      h += int'(out_a[0]);
    end
    n_run++;
    if (h != 2) begin
      n_fail++;
      $display("FAIL last_wins_high: got %0d want 2", h);
    end
  endtask

  task automatic test_inv();
    bit found;
    int h0, l1;
    h0 = 0; l1 = 0;
    duty = {4'd15, 4'd0};
    inv = 2'b01;
    load = 1'b1;
    cyc();
    load = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      cyc();
      if (ps_a) found = 1'b1;
    end
    n_run++;
    if (!found) begin
      n_fail++;
      $display("FAIL inv_boundary: got none want period_start");
    end
    for (int i = 0; i < 16; i++) begin
      cyc();
      h0 += int'(out_a[0]);
      l1 += int'(!out_a[1]);
      n_run++;
      if (obs_b !== exp_v(1)) begin
        n_fail++;
        $display("FAIL inv_b cyc %0d: got %b want %b", i, obs_b, exp_v(1));
      end
    end
    n_run += 2;
    if (h0 != 16) begin
      n_fail++;
      $display("FAIL inv_duty0_high: got %0d want 16", h0);
    end
    if (l1 != 1) begin
      n_fail++;
      $display("FAIL inv_dutymax_low: got %0d want 1", l1);
    end
  endtask

  task automatic test_en_toggle();
    inv = 2'b10;
    cyc(5);
    en = 1'b0;
    cyc();
    n_run++;
    if (out_a !== 2'b10 || ps_a !== 1'b0) begin
      n_fail++;
      $display("FAIL en_off: got out %b ps %b want 10 0", out_a, ps_a);
    end
    duty = {4'd0, 4'd9};
    load = 1'b1;
    cyc();
    load = 1'b0;
    n_run++;
    if (pend_a !== 1'b1) begin
      n_fail++;
      $display("FAIL en_off_load: got %b want 1", pend_a);
    end
    cyc(3);
    en = 1'b1;
    cyc();
    n_run++;
    if (ps_a !== 1'b1 || ps_b !== 1'b1) begin
      n_fail++;
      $display("FAIL en_on_start: got %b%b want 11", ps_a, ps_b);
    end
    cyc();
    n_run++;
    if (out_a !== 2'b11 || pend_a !== 1'b0) begin
      n_fail++;
      $display("FAIL en_on_duty: got %b %b want 11 0", out_a, pend_a);
    end
    for (int i = 0; i < 20; i++) begin
      cyc();
      n_run += 2;
      if (obs_a !== exp_v(0)) begin
        n_fail++;
        $display("FAIL en_a cyc %0d: got %b want %b", i, obs_a, exp_v(0));
      end
      if (obs_b !== exp_v(1)) begin
        n_fail++;
        $display("FAIL en_b cyc %0d: got %b want %b", i, obs_b, exp_v(1));
      end
    end
    inv = 2'b00;
  endtask

  task automatic test_async_reset();
    duty = {4'd7, 4'd11};
    cyc(6);
    load = 1'b1;
    cyc();
    load = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    n_run++;
    if ({obs_a, obs_b} !== '0) begin
      n_fail++;
      $display("FAIL async_reset: got %b want 0", {obs_a, obs_b});
    end
    m[0] = mdl_reset(0);
    m[1] = mdl_reset(2);
    #2;
    rst = 1'b1;
    for (int i = 0; i < 30; i++) begin
      cyc();
      n_run += 2;
      if (obs_a !== exp_v(0)) begin
        n_fail++;
        $display("FAIL rst_a cyc %0d: got %b want %b", i, obs_a, exp_v(0));
      end
      if (obs_b !== exp_v(1)) begin
        n_fail++;
        $display("FAIL rst_b cyc %0d: got %b want %b", i, obs_b, exp_v(1));
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      en = ($urandom_range(0, 15) != 0);
      if ($urandom_range(0, 40) == 0) center = ~center;
      load = ($urandom_range(0, 7) == 0);
      duty = 8'($urandom);
      if ($urandom_range(0, 30) == 0) inv = 2'($urandom);
      cyc();
      n_run += 2;
      if (obs_a !== exp_v(0)) begin
        n_fail++;
        $display("FAIL rand_a cyc %0d: got %b want %b", i, obs_a, exp_v(0));
      end
      if (obs_b !== exp_v(1)) begin
        n_fail++;
        $display("FAIL rand_b cyc %0d: got %b want %b", i, obs_b, exp_v(1));
      end
    end
    load = 1'b0;
  endtask

  initial begin
    m[0] = mdl_reset(0);
    m[1] = mdl_reset(2);
    test_reset();
    test_edge();
    test_center();
    test_last_wins();
    test_inv();
    test_en_toggle();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
